// File: rtl/vga_capture.sv
// VGA receive decoder: checks HS/VS timing, locks after clean frames, and
// reports each frame's bounding box of pixels equal to MATCH_COLOR.
module vga_capture #(
   parameter int         CLK_PER_PIX = 2,
   parameter int         H_VISIBLE   = 640,
   parameter int         H_FRONT     = 16,
   parameter int         H_SYNC      = 96,
   parameter int         H_BACK      = 48,
   parameter int         V_VISIBLE   = 480,
   parameter int         V_FRONT     = 10,
   parameter int         V_SYNC      = 2,
   parameter int         V_BACK      = 33,
   parameter logic [7:0] MATCH_COLOR = 8'hFF
) (
   input  logic       clk50M,
   input  logic       reset,
   input  logic [2:0] red,
   input  logic [2:0] green,
   input  logic [1:0] blue,
   input  logic       HS,
   input  logic       VS,
   output logic       locked,
   output logic       h_err,
   output logic       v_err,
   output logic       frame_valid,
   output logic       obj_found,
   output logic [9:0] obj_x,
   output logic [9:0] obj_y,
   output logic [9:0] obj_w,
   output logic [9:0] obj_h
);

   localparam int              H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int              V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int              PH_W        = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
   localparam logic [PH_W-1:0] PH_LAST     = PH_W'(CLK_PER_PIX - 1);
   localparam logic [11:0]     LINE_CLKS   = 12'(H_TOTAL * CLK_PER_PIX);
   localparam logic [11:0]     HS_CLKS     = 12'(H_SYNC * CLK_PER_PIX);
   localparam logic [10:0]     H_START     = 11'(H_SYNC + H_BACK);
   localparam logic [10:0]     H_END       = 11'(H_SYNC + H_BACK + H_VISIBLE);
   localparam logic [9:0]      V_START     = 10'(V_SYNC + V_BACK);
   localparam logic [9:0]      V_END       = 10'(V_SYNC + V_BACK + V_VISIBLE);
   localparam logic [9:0]      LAST_LINE   = 10'(V_TOTAL - 1);
   localparam logic [9:0]      VS_LINES    = 10'(V_SYNC);
   localparam logic [1:0]      LOCK_FRAMES = 2'd2;

   typedef enum logic {ST_ACQUIRE, ST_LOCKED} state_t;

   state_t          state;
   state_t          state_nxt;

   logic            hs_q;
   logic            vs_q;
   logic [7:0]      rgb_q;
   logic [10:0]     clk_cnt;
   logic [PH_W-1:0] phase;
   logic [10:0]     pix;
   logic [9:0]      line_cnt;
   logic [9:0]      line_cnt_nxt;

   logic            hs_seen;
   logic            hs_w_ok;
   logic            vs_w_ok;
   logic            first_frame;
   logic            dirty;
   logic [1:0]      good_frames;

   logic            hit;
   logic [9:0]      min_x;
   logic [9:0]      min_y;
   logic [9:0]      max_x;
   logic [9:0]      max_y;

   logic            hs_fall;
   logic            hs_rise;
   logic            vs_fall;
   logic            vs_rise;
   logic            line_err;
   logic            frame_evt;
   logic            frame_err;
   logic            frame_bad;
   logic            in_win;
   logic            match;
   logic            publish;
   logic [9:0]      x_pos;
   logic [9:0]      y_pos;

   assign hs_fall = hs_q & ~HS;
   assign hs_rise = ~hs_q & HS;
   assign vs_fall = vs_q & ~VS;
   assign vs_rise = ~vs_q & VS;

   // The first HS fall after reset closes a partial line, so it is not checked.
   assign line_err  = hs_fall & hs_seen &
                      ((({1'b0, clk_cnt} + 12'd1) != LINE_CLKS) | ~hs_w_ok);
   assign frame_evt = vs_fall & ~first_frame;
   assign frame_err = (line_cnt != LAST_LINE) | ~vs_w_ok;
   assign frame_bad = dirty | line_err | frame_err;

   assign in_win = (pix >= H_START) && (pix < H_END) &&
                   (line_cnt >= V_START) && (line_cnt < V_END);
   assign match  = in_win && (phase == PH_LAST) && (rgb_q == MATCH_COLOR);
   assign x_pos  = pix[9:0] - H_START[9:0];
   assign y_pos  = line_cnt - V_START;

   always_comb begin
      line_cnt_nxt = line_cnt;
      if (vs_fall) begin
         line_cnt_nxt = '0;
      end else if (hs_fall && (line_cnt != '1)) begin
         line_cnt_nxt = line_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk50M) begin
      if (reset) begin
         state <= ST_ACQUIRE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACQUIRE: begin
            if (frame_evt && !frame_bad && ((good_frames + 2'd1) == LOCK_FRAMES)) begin
               state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (line_err || (frame_evt && frame_bad)) begin
               state_nxt = ST_ACQUIRE;
            end
         end
         default: state_nxt = ST_ACQUIRE;
      endcase
   end

   always_comb begin
      locked = 1'b0;
      if (state == ST_LOCKED) begin
         locked = 1'b1;
      end
   end

   assign publish = frame_evt && (state_nxt == ST_LOCKED);

   always_ff @(posedge clk50M) begin
      if (reset) begin
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         rgb_q       <= '0;
         clk_cnt     <= '0;
         phase       <= '0;
         pix         <= '0;
         line_cnt    <= '0;
         hs_seen     <= 1'b0;
         hs_w_ok     <= 1'b0;
         vs_w_ok     <= 1'b0;
         first_frame <= 1'b1;
         dirty       <= 1'b0;
         good_frames <= '0;
         hit         <= 1'b0;
         min_x       <= '0;
         min_y       <= '0;
         max_x       <= '0;
         max_y       <= '0;
         h_err       <= 1'b0;
         v_err       <= 1'b0;
         frame_valid <= 1'b0;
         obj_found   <= 1'b0;
         obj_x       <= '0;
         obj_y       <= '0;
         obj_w       <= '0;
         obj_h       <= '0;
      end else begin
         hs_q  <= HS;
         vs_q  <= VS;
         rgb_q <= {red, green, blue};

         if (hs_fall) begin
            clk_cnt <= '0;
            phase   <= '0;
            pix     <= '0;
            hs_seen <= 1'b1;
         end else begin
            if (clk_cnt != '1) begin
               clk_cnt <= clk_cnt + 11'd1;
            end
            if (phase == PH_LAST) begin
               phase <= '0;
               if (pix != '1) begin
                  pix <= pix + 11'd1;
               end
            end else begin
               phase <= phase + PH_W'(1);
            end
         end
         line_cnt <= line_cnt_nxt;

         // Sync widths are measured at the rising edge and judged at the next fall.
         if (hs_rise) begin
            hs_w_ok <= (({1'b0, clk_cnt} + 12'd1) == HS_CLKS);
         end
         if (vs_rise) begin
            vs_w_ok <= (line_cnt_nxt == VS_LINES);
         end

         if (vs_fall) begin
            first_frame <= 1'b0;
            dirty       <= 1'b0;
         end else if (line_err) begin
            dirty <= 1'b1;
         end

         if (state == ST_ACQUIRE) begin
            if (frame_evt) begin
               good_frames <= (frame_bad || (state_nxt == ST_LOCKED)) ? 2'd0 : good_frames + 2'd1;
            end else if (line_err) begin
               good_frames <= '0;
            end
         end else begin
            good_frames <= '0;
         end

         if (state == ST_LOCKED && line_err) begin
            h_err <= 1'b1;
         end
         if (state == ST_LOCKED && frame_evt && frame_err) begin
            v_err <= 1'b1;
         end

         if (vs_fall) begin
            hit   <= 1'b0;
            min_x <= '0;
            min_y <= '0;
            max_x <= '0;
            max_y <= '0;
         end else if (match) begin
            hit <= 1'b1;
            if (!hit) begin
               min_x <= x_pos;
               max_x <= x_pos;
               min_y <= y_pos;
               max_y <= y_pos;
            end else begin
               if (x_pos < min_x) min_x <= x_pos;
               if (x_pos > max_x) max_x <= x_pos;
               if (y_pos < min_y) min_y <= y_pos;
               if (y_pos > max_y) max_y <= y_pos;
            end
         end

         frame_valid <= publish;
         if (publish) begin
            obj_found <= hit;
            if (hit) begin
               obj_x <= min_x;
               obj_y <= min_y;
               obj_w <= max_x - min_x + 10'd1;
               obj_h <= max_y - min_y + 10'd1;
            end
         end
      end
   end

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side decoder for the Pong VGA output. It samples the 3-3-2 RGB and HS/VS lines on the 50 MHz system clock and checks them against 640x480@60 timing. Each frame it reports the bounding box of pixels matching a target colour, such as the ball. It sits beside the graphics generator in self-check builds and in the testbench, closing the loop on rendered ball/paddle positions.

## Interface
- CLK_PER_PIX, 2: system clocks per pixel.
- H_VISIBLE / H_FRONT / H_SYNC / H_BACK, 640 / 16 / 96 / 48: horizontal timing in pixels; H_TOTAL = sum = 800.
- V_VISIBLE / V_FRONT / V_SYNC / V_BACK, 480 / 10 / 2 / 33: vertical timing in lines; V_TOTAL = 525.
- MATCH_COLOR, 8'hFF: {red,green,blue} value counted as object.
- clk50M  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- red  in  3  pixel red.
- green  in  3  pixel green.
- blue  in  2  pixel blue.
- HS  in  1  horizontal sync, active low.
- VS  in  1  vertical sync, active low.
- locked  out  1  timing lock achieved.
- h_err  out  1  sticky: bad line period or HS width seen while locked.
- v_err  out  1  sticky: bad frame line count or VS width seen while locked.
- frame_valid  out  1  one-clock pulse: object outputs updated.
- obj_found  out  1  last completed frame contained ≥1 matching pixel.
- obj_x, obj_y  out  10 each  top-left of matching bounding box (visible coordinates).
- obj_w, obj_h  out  10 each  bounding box width/height in pixels/lines.

## Operation
- Inputs are same-domain. Register them once (hs_q, vs_q, rgb_q). Fall = previous 1, current 0.
- HS fall: clk_cnt (11 b) ← 0, phase ← 0, pix ← 0, line_cnt += 1. Otherwise clk_cnt += 1 (saturates at 2047). phase wraps 0..CLK_PER_PIX-1, and pix increments on wrap.
- VS fall: line_cnt ← 0. This has priority over a same-edge HS fall. line_cnt is 10 b and saturates at 1023.
- Visible window: pix in [H_SYNC+H_BACK, +H_VISIBLE) and line_cnt in [V_SYNC+V_BACK, +V_VISIBLE). Sample at phase == CLK_PER_PIX-1. x = pix-144, y = line_cnt-35.
- Match (rgb_q == MATCH_COLOR in window): update min_x/min_y/max_x/max_y and set hit. Accumulators are cleared at each VS fall, after their values are transferred.
- Line check at each HS fall: previous clk_cnt+1 must equal H_TOTAL*CLK_PER_PIX (1600). HS low duration must equal H_SYNC*CLK_PER_PIX (192) clocks.
- Frame check at each VS fall: line count must equal V_TOTAL-1. VS low span must equal V_SYNC lines.
- The first VS fall after reset only starts measurement and produces no frame check or frame_valid.
- FSM:
  - ACQUIRE (reset state): good_frames counts consecutive frames with no line or frame errors. When it reaches 2, go to LOCKED and set locked=1. Any error resets good_frames to 0.
  - LOCKED: an error → ACQUIRE and locked=0. A line error sets h_err; a frame error sets v_err.
  - h_err and v_err are not set in ACQUIRE. They clear only on reset.
- At a VS fall that completes a checked frame with locked=1 (including the frame that achieves lock), then on that edge:
  - obj_found ← hit.
  - If hit: obj_x ← min_x, obj_y ← min_y, obj_w ← max_x-min_x+1, obj_h ← max_y-min_y+1. If not hit, obj_* hold.
  - frame_valid ← 1 for one clock.

## Timing
- Reset: every output is 0, FSM is in ACQUIRE, all counters and accumulators are 0, and the first-frame flag is set.
- Input-to-edge-detect latency: 1 clock (register stage).
- frame_valid asserts in the cycle after the edge where vs_q=1 and VS=0 is registered.
- Reset mid-frame discards all partial accumulation. Lock therefore needs the first VS fall plus 2 full good frames, giving the first frame_valid at the 3rd VS fall after reset.
- Simultaneous HS fall and VS fall: line_cnt ← 0 and the line check still runs.
- Sync held low forever: counters saturate, and the next edge flags an error if locked.
- Arithmetic is unsigned. The window compare uses full counter widths, with no wrap.

## Test plan
- Clean 640x480 frames with a 16x16 block of 8'hFF at (320,240): locked=1 after 3rd VS fall, and frame_valid then gives obj_x=320, obj_y=240, obj_w=16, obj_h=16, obj_found=1.
- All-black frames after lock: frame_valid pulses with obj_found=0, and obj_* hold their previous values.
- Single-pixel matches at (0,0) and (639,479) in the same frame: obj_x=0, obj_y=0, obj_w=640, obj_h=480.
- One line of 1602 clocks while locked: locked drops on that HS fall, h_err=1 sticky, and relock occurs after 2 good frames with h_err still 1.
- Frame with 524 lines while locked: v_err=1, locked=0, and no frame_valid at that VS fall.
- Assert reset mid-frame while locked: all outputs go to 0 on the next clock, and the first frame_valid arrives at the 3rd VS fall after reset release.
